fifo_stream_reader: RTL and testbench

Read-side adapter for the project's synchronous `fifo`: drives `ren`, captures `read_data` one cycle later, and presents words downstream as a valid/ready stream. It sits between a command/pixel FIFO and the consuming pipeline stage. A 3-entry holding buffer sustains one word per cycle with no combinational path from `m_ready` to `fifo_ren`.

---
 rtl/fifo_stream_pkg.sv | 9 +
 rtl/stream_buf3.sv | 36 +++
 rtl/fifo_stream_reader.sv | 46 ++++
 tb/tb_fifo_stream_reader.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/fifo_stream_pkg.sv
// fifo_stream_pkg: shared depth, pointer type and 0->1->2->0 wrap helper for the FIFO stream reader
package fifo_stream_pkg;
  localparam int BUF_DEPTH = 3;
  localparam int PTR_W = 2;
  typedef logic [PTR_W-1:0] ptr_t;
  function automatic ptr_t next_ptr(input ptr_t p);
    return (p == ptr_t'(BUF_DEPTH - 1)) ? '0 : p + ptr_t'(1);
  endfunction
endpackage

// File: rtl/stream_buf3.sv
// stream_buf3: 3-entry circular register buffer (clk/reset/clr, wr+wdata in, rd strobe, rdata=head word, occ=occupancy)
module stream_buf3 import fifo_stream_pkg::*; #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             wr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd,
  output logic [WIDTH-1:0] rdata,
  output logic [PTR_W-1:0] occ
);
  ptr_t head, tail;
  logic [WIDTH-1:0] mem [BUF_DEPTH];
  assign rdata = mem[head];
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head <= '0;
      tail <= '0;
      occ <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
    end else if (clr) begin
      head <= '0;
      tail <= '0;
      occ <= '0;
    end else begin
      if (wr) begin
        mem[tail] <= wdata;
        tail <= next_ptr(tail);
      end
      if (rd) head <= next_ptr(head);
      occ <= occ + PTR_W'(wr) - PTR_W'(rd);
    end
  end
endmodule

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: FIFO read adapter (fifo_empty/fifo_ren/fifo_rdata) to valid/ready stream (m_valid/m_ready/m_data) with flush and pop_count
module fifo_stream_reader import fifo_stream_pkg::*; #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fifo_empty,
  output logic             fifo_ren,
  input  logic [WIDTH-1:0] fifo_rdata,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  input  logic             flush,
  output logic [CNT_W-1:0] pop_count
);
  logic inflight, drop, hs, wr;
  logic [PTR_W-1:0] occ;
  // Issue only when the buffer can absorb every word already requested, so m_ready never reaches fifo_ren.
  assign fifo_ren = reset && !flush && !fifo_empty && (({1'b0, occ} + {2'b0, inflight}) < 3'(BUF_DEPTH));
  assign m_valid = occ != '0;
  assign hs = m_valid && m_ready;
  assign wr = inflight && !drop;
  // The buffer's clear outranks its write, so a word landing during flush is discarded too.
  stream_buf3 #(.WIDTH(WIDTH)) u_buf (
    .clk(clk),
    .reset(reset),
    .clr(flush),
    .wr(wr),
    .wdata(fifo_rdata),
    .rd(hs),
    .rdata(m_data),
    .occ(occ)
  );
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inflight <= 1'b0;
      drop <= 1'b0;
      pop_count <= '0;
    end else begin
      inflight <= fifo_ren;
      drop <= flush && inflight;
      if (hs) pop_count <= pop_count + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: directed steps with FIFO model and scoreboard queue for fifo_stream_reader
module tb_fifo_stream_reader;
  localparam int WIDTH = 4;
  localparam int CNT_W = 4;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic m_ready = 1'b0;
  logic flush = 1'b0;
  logic flush_seen = 1'b0;
  logic fifo_empty, fifo_ren, m_valid;
  logic [WIDTH-1:0] fifo_rdata = '0;
  logic [WIDTH-1:0] m_data;
  logic [CNT_W-1:0] pop_count;
  logic [CNT_W-1:0] pc;
  logic [WIDTH-1:0] mem [256];
  logic [WIDTH-1:0] exp_q [$];
  int rd_ptr = 0;
  int wr_ptr = 0;
  int delivered = 0;
  int exp_cnt = 0;
  int checks = 0;
  int errors = 0;
  int n, d0, h;
  always #5 clk = ~clk;
  assign fifo_empty = rd_ptr == wr_ptr;
  fifo_stream_reader #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .reset(reset),
    .fifo_empty(fifo_empty),
    .fifo_ren(fifo_ren),
    .fifo_rdata(fifo_rdata),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data(m_data),
    .flush(flush),
    .pop_count(pop_count)
  );
  always @(posedge clk) begin
    flush_seen <= flush;
    if (fifo_ren) begin
      fifo_rdata <= mem[rd_ptr[7:0]];
      rd_ptr <= rd_ptr + 1;
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!reset || flush_seen) begin
      while (delivered < rd_ptr) begin
        void'(exp_q.pop_front());
        delivered++;
      end
      if (!reset) exp_cnt = 0;
    end
    chk("pop_count", 32'(pop_count), 32'(exp_cnt % 16));
    if (dut.inflight && !dut.drop) chk("no_overflow", 32'(dut.occ != 2'd3), 1);
    if (m_valid && m_ready) begin
      if (exp_q.size() == 0) chk("scoreboard_size", 32'(exp_q.size()), 1);
      else chk("m_data", 32'(m_data), 32'(exp_q.pop_front()));
      delivered++;
      exp_cnt++;
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [WIDTH-1:0] v);
    mem[wr_ptr[7:0]] = v;
    exp_q.push_back(v);
    wr_ptr++;
  endtask
  task automatic wait_valid(input string tag);
    for (int i = 0; i < 12 && !m_valid; i++) tick();
    chk(tag, 32'(m_valid), 1);
  endtask
  task automatic drain(input string tag);
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) tick();
    chk(tag, 32'(exp_q.size()), 0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    for (int i = 0; i < 9; i++) push(WIDTH'(i));
    m_ready = 1'b1;
    tick();
    tick();
    chk("rst_fifo_ren", 32'(fifo_ren), 0);
    chk("rst_m_valid", 32'(m_valid), 0);
    chk("rst_m_data", 32'(m_data), 0);
    chk("rst_pop_count", 32'(pop_count), 0);
    reset = 1'b1;
    wait_valid("fill_valid");
    for (int i = 0; i < 9; i++) begin
      chk("fill_order", 32'(m_data), i);
      tick();
    end
    chk("fill_pop_count", 32'(pop_count), 9);
    chk("fill_m_valid_end", 32'(m_valid), 0);
    chk("fill_ren_empty", 32'(fifo_ren), 0);
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(WIDTH'(9 + i));
    #1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      n += int'(fifo_ren);
      tick();
    end
    chk("stall_ren_pulses", n, 3);
    chk("stall_m_valid", 32'(m_valid), 1);
    chk("stall_head", 32'(m_data), 9);
    chk("stall_ren_low", 32'(fifo_ren), 0);
    m_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("stall_release_valid", 32'(m_valid), 1);
      chk("stall_release_order", 32'(m_data), 9 + i);
      tick();
    end
    chk("stall_release_end", 32'(m_valid), 0);
    for (int i = 0; i < 9; i++) push(WIDTH'(14 + i));
    d0 = delivered;
    for (int i = 0; i < 30; i++) begin
      m_ready = (i % 2) == 0;
      tick();
    end
    chk("alt_count", delivered - d0, 9);
    chk("alt_sb_empty", 32'(exp_q.size()), 0);
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) push(WIDTH'(7 + i));
    tick();
    tick();
    tick();
    pc = pop_count;
    flush = 1'b1;
    #1;
    chk("flush_ren_low", 32'(fifo_ren), 0);
    tick();
    flush = 1'b0;
    chk("flush_m_valid", 32'(m_valid), 0);
    m_ready = 1'b1;
    wait_valid("flush_refill");
    chk("flush_next_word", 32'(m_data), 10);
    chk("flush_pop_count", 32'(pop_count), 32'(pc));
    drain("flush_drain");
    chk("flush_drain_count", 32'(pop_count), 32'(CNT_W'(pc + 3)));
    for (int i = 0; i < 8; i++) push(WIDTH'(i + 1));
    tick();
    tick();
    tick();
    tick();
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_ren", 32'(fifo_ren), 0);
    chk("async_rst_valid", 32'(m_valid), 0);
    chk("async_rst_data", 32'(m_data), 0);
    chk("async_rst_count", 32'(pop_count), 0);
    tick();
    tick();
    h = rd_ptr;
    reset = 1'b1;
    wait_valid("resume_valid");
    chk("resume_head", 32'(m_data), 32'(mem[h[7:0]]));
    chk("resume_count", 32'(pop_count), 0);
    drain("resume_drain");
    reset = 1'b0;
    tick();
    reset = 1'b1;
    for (int i = 0; i < 17; i++) push(WIDTH'(i));
    drain("wrap_drain");
    chk("wrap_count", 32'(pop_count), 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
